// File: rtl/spi_core_if.sv
// Slot bus between the MMIO controller and the SPI master peripheral.
// The controller drives the strobes; the core returns combinational read data.
interface spi_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, read, write, reg_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, reg_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/spi_core.sv
// 8-bit SPI master slot: programmable divisor, CPOL/CPHA, S slave selects.
// Timing settings are captured at transfer start so reconfiguration is safe.
module spi_core #(
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         reset,
  spi_core_if.slave    bus,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic [S-1:0] spi_ss_n,
  output logic         spi_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DLY  = 2'd1;
  localparam logic [1:0] P0   = 2'd2;
  localparam logic [1:0] P1   = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [15:0]  c_q, c_d;
  logic [2:0]   n_q, n_d;
  logic [7:0]   tx_q, tx_d;
  logic [7:0]   rx_q, rx_d;
  logic [7:0]   rxb_q, rxb_d;
  logic [15:0]  dv_q, dv_d;
  logic         pol_q, pol_d;
  logic         pha_q, pha_d;
  logic [S-1:0] ss_q;
  logic [15:0]  dvsr_q;
  logic         cpol_q;
  logic         cpha_q;
  logic         wr1, wr2, wr3;
  logic         last;
  logic         ready;

  always_comb begin
    wr1 = 1'b0;
    wr2 = 1'b0;
    wr3 = 1'b0;
    if (bus.cs && bus.write) begin
      unique case (bus.reg_addr)
        5'd1:    wr1 = 1'b1;
        5'd2:    wr2 = 1'b1;
        5'd3:    wr3 = 1'b1;
        default: ;
      endcase
    end
  end

  assign last = (c_q == dv_q);

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    n_d      = n_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rxb_d    = rxb_q;
    dv_d     = dv_q;
    pol_d    = pol_q;
    pha_d    = pha_q;
    spi_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr3) begin
          tx_d    = bus.wr_data[7:0];
          n_d     = 3'd0;
          c_d     = 16'd0;
          dv_d    = dvsr_q;
          pol_d   = cpol_q;
          pha_d   = cpha_q;
          state_d = cpha_q ? DLY : P0;
        end
      end
      DLY: begin
        if (last) begin
          c_d     = 16'd0;
          state_d = P0;
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      P0: begin
        if (last) begin
          c_d     = 16'd0;
          rx_d    = {rx_q[6:0], spi_miso};
          state_d = P1;
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      P1: begin
        if (last) begin
          c_d = 16'd0;
          if (n_q == 3'd7) begin
            rxb_d    = rx_q;
            spi_done = 1'b1;
            state_d  = IDLE;
          end else begin
            tx_d    = {tx_q[6:0], 1'b0};
            n_d     = n_q + 3'd1;
            state_d = P0;
          end
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      n_q     <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxb_q   <= '0;
      dv_q    <= '0;
      pol_q   <= 1'b0;
      pha_q   <= 1'b0;
      ss_q    <= '1;
      dvsr_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      n_q     <= n_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxb_q   <= rxb_d;
      dv_q    <= dv_d;
      pol_q   <= pol_d;
      pha_q   <= pha_d;
      if (wr1) ss_q <= bus.wr_data[S-1:0];
      if (wr2) begin
        dvsr_q <= bus.wr_data[15:0];
        cpol_q <= bus.wr_data[16];
        cpha_q <= bus.wr_data[17];
      end
    end
  end

  assign ready = (state_q == IDLE);

  // Idle clock level tracks the live CPOL so the line settles before a start.
  always_comb begin
    if (ready) spi_sclk = cpol_q;
    else if (pha_q) spi_sclk = pol_q ^ (state_q == P0);
    else spi_sclk = pol_q ^ (state_q == P1);
  end

  assign spi_mosi = !ready && tx_q[7];
  assign spi_ss_n = ss_q;

  assign bus.rd_data = (bus.reg_addr == 5'd0)
                     ? {23'b0, ready, rxb_q}
                     : 32'h0;

  logic unused_bus;
  assign unused_bus = ^{bus.read, bus.wr_data[31:18]};

endmodule

// File: tb/tb_spi_core.sv
// Scoreboard bench for spi_core: stimulus queues expected transfers,
// a monitor checks each spi_done against the queue head.
module tb_spi_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk, mosi, miso, done;
  logic [1:0] ss_n;

  always #5 clk = ~clk;

  spi_core_if bus();

  spi_core #(.S(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .spi_sclk (sclk),
    .spi_mosi (mosi),
    .spi_miso (miso),
    .spi_ss_n (ss_n),
    .spi_done (done)
  );

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    int         start;
    int         busy;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int ecnt  = 0;
  int base  = 0;
  int k;
  logic [7:0] mcap = 8'h00;
  logic [7:0] sb;
  logic       lp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge sclk) begin
    ecnt <= ecnt + 1;
    mcap <= {mcap[6:0], mosi};
  end

  // slave shifts its byte out MSB first, advancing after each rising SCLK
  always_comb begin
    k = ecnt - base;
    if (lp) miso = mosi;
    else if (k >= 0 && k < 8) miso = sb[7-k];
    else miso = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.write = 1'b1; bus.reg_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0; bus.reg_addr = 5'd0; bus.wr_data = 32'h0;
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] rx,
                      input int busy, input logic loop,
                      input logic [7:0] slv, input bit push,
                      output int s);
    @(negedge clk);
    lp = loop; sb = slv;
    bus.cs = 1'b1; bus.write = 1'b1; bus.reg_addr = 5'd3;
    bus.wr_data = {24'h0, tx};
    @(posedge clk);
    #1;
    base = ecnt;
    s    = cyc;
    if (push) q.push_back('{rx, tx, s, busy});
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0; bus.reg_addr = 5'd0; bus.wr_data = 32'h0;
  endtask

  task automatic drop_at(input int at);
    int lim;
    lim = 0;
    while (cyc != at && lim < 200) begin
      @(negedge clk);
      lim++;
    end
    chk("drop_timing", cyc, at);
    bus.cs = 1'b1; bus.write = 1'b1; bus.reg_addr = 5'd3;
    bus.wr_data = 32'h55;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0; bus.reg_addr = 5'd0; bus.wr_data = 32'h0;
  endtask

  initial begin
    int s;
    int lim;
    reset = 1'b1;
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.reg_addr = 5'd0; bus.wr_data = 32'h0;
    lp = 1'b0; sb = 8'h00;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (done) begin
            if (q.size() == 0) begin
              chk("spurious_done", {31'b0, done}, 32'h0);
            end else begin
              e = q.pop_front();
              chk("busy_cycles", cyc - e.start + 1, e.busy);
              chk("sclk_edges", ecnt - base, 8);
              chk("mosi_byte", {24'h0, mcap}, {24'h0, e.tx});
              @(negedge clk);
              #1;
              chk("rd_rx", bus.rd_data, {23'b0, 1'b1, e.rx});
            end
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_rd", bus.rd_data, 32'h100);
    chk("rst_ss", {30'h0, ss_n}, 32'h3);
    chk("rst_sclk", {31'h0, sclk}, 32'h0);
    chk("rst_mosi", {31'h0, mosi}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    reset = 1'b0;

    // mode 0, dvsr=1, loopback
    wr(5'd2, 32'h1);
    xfer(8'hA5, 8'hA5, 32, 1'b1, 8'h00, 1'b1, s);
    repeat (40) @(negedge clk);

    // mode 0, dvsr=0 (clk/2)
    wr(5'd2, 32'h0);
    xfer(8'h96, 8'h5A, 16, 1'b0, 8'h5A, 1'b1, s);
    repeat (25) @(negedge clk);

    // mode 3, dvsr=0
    wr(5'd2, 32'h3_0000);
    chk("m3_idle_sclk", {31'h0, sclk}, 32'h1);
    xfer(8'h81, 8'h3C, 17, 1'b0, 8'h3C, 1'b1, s);
    repeat (25) @(negedge clk);
    chk("m3_idle_after", {31'h0, sclk}, 32'h1);

    // starts dropped mid-transfer and in the done cycle
    wr(5'd2, 32'h1);
    xfer(8'hF0, 8'hF0, 32, 1'b1, 8'h00, 1'b1, s);
    drop_at(s + 10);
    drop_at(s + 31);
    repeat (40) @(negedge clk);
    chk("drop_idle", bus.rd_data, 32'h1F0);

    // slave selects
    wr(5'd1, 32'h2);
    chk("ss_10", {30'h0, ss_n}, 32'h2);
    wr(5'd1, 32'h3);
    chk("ss_11", {30'h0, ss_n}, 32'h3);
    wr(5'd1, 32'h1);
    chk("ss_01", {30'h0, ss_n}, 32'h1);

    // reset during the 4th bit (its P1 phase)
    xfer(8'hFF, 8'h00, 0, 1'b1, 8'h00, 1'b0, s);
    lim = 0;
    while (cyc != s + 14 && lim < 200) begin
      @(negedge clk);
      lim++;
    end
    chk("mid_sclk_hi", {31'h0, sclk}, 32'h1);
    chk("mid_mosi_hi", {31'h0, mosi}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rr_rd", bus.rd_data, 32'h100);
    chk("rr_sclk", {31'h0, sclk}, 32'h0);
    chk("rr_mosi", {31'h0, mosi}, 32'h0);
    chk("rr_ss", {30'h0, ss_n}, 32'h3);
    repeat (40) @(negedge clk);
    chk("rr_still_idle", bus.rd_data, 32'h100);

    // divisor change mid-transfer only affects the next transfer
    wr(5'd2, 32'h1);
    xfer(8'h5A, 8'h5A, 32, 1'b1, 8'h00, 1'b1, s);
    wr(5'd2, 32'h3);
    repeat (40) @(negedge clk);
    xfer(8'h3C, 8'h3C, 64, 1'b1, 8'h00, 1'b1, s);
    repeat (75) @(negedge clk);

    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
